// File: rtl/rr_timeout_arbiter_pkg.sv
// rr_timeout_arbiter_pkg: flit-type codes and index-width helper shared by the arbiter files
package rr_timeout_arbiter_pkg;
  localparam int FLIT_HEAD = 1;
  localparam int FLIT_BODY = 2;
  localparam int FLIT_TAIL = 3;
  localparam int HEAD_ID_DEF = FLIT_HEAD;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_timeout_arbiter_hold_timer.sv
// hold_timer: hold-cycle counter for the live grant, flags when its budget is used up
module hold_timer #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic [LEN_W-1:0] limit,
  output logic [LEN_W-1:0] cnt,
  output logic             expired
);
  logic [LEN_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = start ? LEN_W'(1) : hold ? cnt_q + LEN_W'(cnt_q != '1) : '0;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
  assign expired = cnt_q >= limit;
endmodule

// File: rtl/rr_timeout_arbiter.sv
// rr_timeout_arbiter: N-port round-robin arbiter with per-port hold budgets latched from head flits
module rr_timeout_arbiter
  import rr_timeout_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int LEN_W = 12,
  parameter int FID_W = 3,
  parameter int HEAD_ID = HEAD_ID_DEF,
  parameter int REGRANT = 1,
  localparam int IW = idx_w(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       req,
  input  logic [NUM_PORTS*FID_W-1:0] flit_id,
  input  logic [NUM_PORTS*LEN_W-1:0] length,
  output logic [NUM_PORTS-1:0]       grant,
  output logic                       grant_valid,
  output logic [IW-1:0]              grant_id,
  output logic                       timeout
);
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IW-1:0] id_q, id_d, ptr_q, ptr_d, base, win;
  logic valid_q, valid_d, to_q, to_d;
  logic [LEN_W-1:0] limit_q [NUM_PORTS];
  logic [LEN_W-1:0] limit_d [NUM_PORTS];
  logic [LEN_W-1:0] cnt;
  logic busy, expired, hold, skip, found, start;
  hold_timer #(.LEN_W(LEN_W)) u_timer (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .limit(limit_q[id_q]), .cnt(cnt), .expired(expired)
  );
  // cnt is non-zero exactly while a grant is live (starts at 1, saturates)
  assign busy = |cnt;
  assign hold = busy && req[id_q] && !expired;
  assign skip = busy && req[id_q] && expired && REGRANT == 0;
  assign base = busy ? id_q : ptr_q;
  assign start = found && !hold;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = 1; k <= NUM_PORTS; k++)
      if (!found && req[(int'(base) + k) % NUM_PORTS] && !(skip && (int'(base) + k) % NUM_PORTS == int'(id_q))) begin
        found = 1'b1;
        win = IW'((int'(base) + k) % NUM_PORTS);
      end
    id_d = hold ? id_q : win;
    valid_d = hold || found;
    grant_d = NUM_PORTS'(valid_d) << id_d;
    to_d = busy && req[id_q] && expired;
    ptr_d = start ? win : ptr_q;
    for (int i = 0; i < NUM_PORTS; i++)
      limit_d[i] = flit_id[i*FID_W +: FID_W] == FID_W'(HEAD_ID) ? length[i*LEN_W +: LEN_W] : limit_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      id_q <= '0;
      valid_q <= 1'b0;
      to_q <= 1'b0;
      ptr_q <= IW'(NUM_PORTS - 1);
    end else begin
      grant_q <= grant_d;
      id_q <= id_d;
      valid_q <= valid_d;
      to_q <= to_d;
      ptr_q <= ptr_d;
    end
    for (int i = 0; i < NUM_PORTS; i++) limit_q[i] <= rst ? '0 : limit_d[i];
  end
  assign grant = grant_q;
  assign grant_valid = valid_q;
  assign grant_id = id_q;
  assign timeout = to_q;
endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// tb_rr_timeout_arbiter: scoreboard bench for REGRANT=1/0 five-port arbiters plus an 8-port random run
module tb_rr_timeout_arbiter;
  import rr_timeout_arbiter_pkg::*;
  typedef struct {logic [4:0] g; logic t;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] req = '0;
  logic [14:0] fid = '0;
  logic [59:0] len = '0;
  logic [4:0] g0, g1;
  logic v0, v1, to0, to1;
  logic [2:0] id0, id1;
  logic [7:0] req8 = '0, g8;
  logic [23:0] fid8 = '0;
  logic [31:0] len8 = '0;
  logic v8, to8;
  logic [2:0] id8;
  int pass = 0, total = 0;
  int wt [8];
  bit on8 = 1'b0;
  exp_t q0 [$];
  exp_t q1 [$];
  always #5 clk = ~clk;
  rr_timeout_arbiter #(.REGRANT(1)) dut0 (.clk(clk), .rst(rst), .req(req), .flit_id(fid), .length(len),
    .grant(g0), .grant_valid(v0), .grant_id(id0), .timeout(to0));
  rr_timeout_arbiter #(.REGRANT(0)) dut1 (.clk(clk), .rst(rst), .req(req), .flit_id(fid), .length(len),
    .grant(g1), .grant_valid(v1), .grant_id(id1), .timeout(to1));
  rr_timeout_arbiter #(.NUM_PORTS(8), .LEN_W(4)) dut8 (.clk(clk), .rst(rst), .req(req8), .flit_id(fid8),
    .length(len8), .grant(g8), .grant_valid(v8), .grant_id(id8), .timeout(to8));
  function automatic logic [2:0] oh2i(input logic [7:0] g);
    oh2i = '0;
    for (int i = 0; i < 8; i++) if (g[i]) oh2i = 3'(i);
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, a, e, $time);
  endtask
  task automatic look(input string nm, input exp_t e, input logic [4:0] g, input logic v,
                      input logic [2:0] id, input logic t);
    chk({nm, ".grant"}, 32'(g), 32'(e.g));
    chk({nm, ".valid"}, 32'(v), 32'(|e.g));
    chk({nm, ".id"}, 32'(id), 32'(oh2i(8'(e.g))));
    chk({nm, ".timeout"}, 32'(t), 32'(e.t));
  endtask
  always @(negedge clk) begin
    if (q0.size() > 0) look("regrant1", q0.pop_front(), g0, v0, id0, to0);
    if (q1.size() > 0) look("regrant0", q1.pop_front(), g1, v1, id1, to1);
    if (on8) begin
      bit late;
      late = 1'b0;
      chk("p8.onehot", 32'($onehot0(g8)), 32'd1);
      chk("p8.valid", 32'(v8), 32'(|g8));
      chk("p8.id", 32'(id8), 32'(oh2i(g8)));
      for (int i = 0; i < 8; i++) begin
        wt[i] = (g8[i] || !req8[i]) ? 0 : wt[i] + 1;
        if (wt[i] > 130) late = 1'b1;
      end
      chk("p8.fair", 32'(late), 32'd0);
    end
  end
  task automatic cyc(input logic [4:0] r, input logic hd, input logic [11:0] l,
                     input logic [4:0] e0, input logic t0, input logic [4:0] e1, input logic t1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    req = r;
    for (int i = 0; i < 5; i++) begin
      fid[i*3 +: 3] = hd ? 3'(FLIT_HEAD) : 3'(FLIT_BODY);
      len[i*12 +: 12] = l;
    end
    q0.push_back('{e0, t0});
    q1.push_back('{e1, t1});
  endtask
  task automatic rcyc(input logic [4:0] r);
    @(negedge clk);
    #1;
    rst = 1'b1;
    req = r;
    q0.push_back('{5'b0, 1'b0});
    q1.push_back('{5'b0, 1'b0});
  endtask
  initial begin
    for (int i = 0; i < 8; i++) wt[i] = 0;
    rcyc(5'b0);
    rcyc(5'b0);
    on8 = 1'b1;
    cyc(5'b00001, 1, 3, 5'b00001, 0, 5'b00001, 0);
    cyc(5'b00001, 1, 3, 5'b00001, 0, 5'b00001, 0);
    cyc(5'b00001, 1, 3, 5'b00001, 0, 5'b00001, 0);
    cyc(5'b00001, 1, 3, 5'b00001, 1, 5'b00000, 1);
    cyc(5'b00001, 1, 3, 5'b00001, 0, 5'b00001, 0);
    cyc(5'b00000, 1, 3, 5'b00000, 0, 5'b00000, 0);
    rcyc(5'b0);
    for (int k = 0; k < 12; k++) begin
      logic [4:0] g;
      logic t;
      g = 5'(1 << ((k / 2) % 5));
      t = (k % 2 == 0) && k > 0;
      cyc(5'b11111, 1, 2, g, t, g, t);
    end
    cyc(5'b00000, 1, 2, 5'b0, 0, 5'b0, 0);
    rcyc(5'b0);
    cyc(5'b00100, 1, 100, 5'b00100, 0, 5'b00100, 0);
    repeat (3) cyc(5'b10101, 1, 100, 5'b00100, 0, 5'b00100, 0);
    cyc(5'b10001, 1, 100, 5'b10000, 0, 5'b10000, 0);
    cyc(5'b10001, 1, 100, 5'b10000, 0, 5'b10000, 0);
    cyc(5'b00000, 1, 100, 5'b0, 0, 5'b0, 0);
    rcyc(5'b0);
    for (int k = 0; k < 6; k++)
      cyc(5'b00010, 1, 0, 5'b00010, k > 0, (k % 2) ? 5'b0 : 5'b00010, 1'(k % 2));
    cyc(5'b00000, 1, 0, 5'b0, 0, 5'b0, 0);
    rcyc(5'b0);
    cyc(5'b01000, 1, 10, 5'b01000, 0, 5'b01000, 0);
    repeat (4) cyc(5'b00000, 1, 10, 5'b0, 0, 5'b0, 0);
    cyc(5'b01001, 1, 10, 5'b00001, 0, 5'b00001, 0);
    cyc(5'b01001, 1, 10, 5'b00001, 0, 5'b00001, 0);
    cyc(5'b00000, 1, 10, 5'b0, 0, 5'b0, 0);
    rcyc(5'b0);
    cyc(5'b10000, 1, 50, 5'b10000, 0, 5'b10000, 0);
    cyc(5'b10000, 1, 50, 5'b10000, 0, 5'b10000, 0);
    rcyc(5'b10000);
    cyc(5'b10001, 0, 50, 5'b00001, 0, 5'b00001, 0);
    cyc(5'b10001, 0, 50, 5'b10000, 1, 5'b10000, 1);
    cyc(5'b10001, 0, 50, 5'b00001, 1, 5'b00001, 1);
    cyc(5'b00000, 0, 50, 5'b0, 0, 5'b0, 0);
    for (int i = 0; i < 8; i++) begin
      fid8[i*3 +: 3] = 3'(FLIT_HEAD);
      len8[i*4 +: 4] = 4'hF;
    end
    repeat (400) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 8; i++) req8[i] = $urandom_range(0, 3) != 0;
    end
    @(negedge clk);
    #1;
    req8 = '0;
    repeat (3) @(negedge clk);
    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
